hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipe_pkg.sv | 18 +
 rtl/ld_use_det.sv | 22 ++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, flush depth,
// register-index width and the NOP instruction word.
package pipe_pkg;

   localparam int          REG_W       = 5;
   localparam int          FLUSH_DEPTH = 2;
   localparam logic [31:0] NOP         = 32'hdc000000;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_FLUSH   = 2'd1,
      ST_MEMWAIT = 2'd2,
      ST_RSVD    = 2'd3
   } hz_state_t;

   localparam logic [1:0] FCNT_LOAD = 2'(FLUSH_DEPTH);

endpackage

// File: rtl/ld_use_det.sv
// Load-use hazard detector: flags a decode-stage source that depends on
// the load currently in EX. Register 0 never creates a dependency.
module ld_use_det
   import pipe_pkg::*;
(
   input  logic             ex_load,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   output logic             hazard
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = id_use_rs & (id_rs == ex_rd);
   assign rt_hit = id_use_rt & (id_rt == ex_rd);
   assign hazard = ex_load & (ex_rd != '0) & (rs_hit | rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stall, jump flush sequencing and
// load-use bubbles. Optional performance counters via HAZ_PERF_CNT_EN.
module hazard_ctrl
   import pipe_pkg::*;
(
   input  logic             clk,
   input  logic             rstd,
   input  logic [1:0]       jon_d,
   input  logic             ex_load,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             mem_req,
   input  logic             mem_ack,
   output logic             pc_en,
   output logic             fd_en,
   output logic             em_en,
   output logic             fd_flush,
   output logic             de_flush,
   output logic [1:0]       state,
   output logic [31:0]      stall_cycles,
   output logic [31:0]      flush_cycles
);

   hz_state_t  state_q, state_nx;
   logic [1:0] fcnt_q, fcnt_nx;
   logic       saved_q, saved_nx;   // 1 = MEMWAIT was entered from FLUSH
   logic       mem_wait;
   logic       ld_hazard;

   assign mem_wait = mem_req & ~mem_ack;
   assign state    = state_q;

   ld_use_det u_ld_use_det (
      .ex_load   (ex_load),
      .ex_rd     (ex_rd),
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .id_use_rs (id_use_rs),
      .id_use_rt (id_use_rt),
      .hazard    (ld_hazard)
   );

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         state_q <= ST_RUN;
         fcnt_q  <= 2'd0;
         saved_q <= 1'b0;
      end else begin
         state_q <= state_nx;
         fcnt_q  <= fcnt_nx;
         saved_q <= saved_nx;
      end
   end

   always_comb begin
      state_nx = state_q;
      fcnt_nx  = fcnt_q;
      saved_nx = saved_q;
      pc_en    = 1'b1;
      fd_en    = 1'b1;
      em_en    = 1'b1;
      fd_flush = 1'b0;
      de_flush = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_wait) begin
               pc_en    = 1'b0;
               fd_en    = 1'b0;
               em_en    = 1'b0;
               state_nx = ST_MEMWAIT;
               saved_nx = 1'b0;
            end else if (jon_d[1]) begin
               fd_flush = 1'b1;
               state_nx = ST_FLUSH;
               fcnt_nx  = FCNT_LOAD;
            end else if (jon_d[0]) begin
               fd_flush = 1'b1;
            end else if (ld_hazard) begin
               pc_en    = 1'b0;
               fd_en    = 1'b0;
               de_flush = 1'b1;
            end
         end

         ST_FLUSH: begin
            if (mem_wait) begin
               pc_en    = 1'b0;
               fd_en    = 1'b0;
               em_en    = 1'b0;
               state_nx = ST_MEMWAIT;
               saved_nx = 1'b1;
            end else begin
               fd_flush = 1'b1;
               if (jon_d[1]) begin
                  fcnt_nx = FCNT_LOAD;
               end else begin
                  // A stray zero count also falls back to RUN.
                  fcnt_nx = (fcnt_q != 2'd0) ? fcnt_q - 2'd1 : 2'd0;
                  if (fcnt_q <= 2'd1) state_nx = ST_RUN;
               end
            end
         end

         ST_MEMWAIT: begin
            if (mem_ack) begin
               state_nx = saved_q ? ST_FLUSH : ST_RUN;
            end else begin
               pc_en = 1'b0;
               fd_en = 1'b0;
               em_en = 1'b0;
            end
         end

         default: begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            em_en    = 1'b0;
            state_nx = ST_RUN;
         end
      endcase

      // Held in reset: freeze the pipe and keep NOPs in both latches.
      if (!rstd) begin
         pc_en    = 1'b0;
         fd_en    = 1'b0;
         em_en    = 1'b0;
         fd_flush = 1'b1;
         de_flush = 1'b1;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_q;
   logic [31:0] flush_q;

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         stall_q <= 32'd0;
         flush_q <= 32'd0;
      end else begin
         if (!pc_en)               stall_q <= stall_q + 32'd1;
         if (fd_flush | de_flush)  flush_q <= flush_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_cycles = flush_q;
`else
   assign stall_cycles = 32'd0;
   assign flush_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table vectors, random load-use
// vectors and hand-written multi-cycle sequences.
module tb_hazard_ctrl;

   logic        clk;
   logic        rstd;
   logic [1:0]  jon_d;
   logic        ex_load;
   logic [4:0]  ex_rd, id_rs, id_rt;
   logic        id_use_rs, id_use_rt;
   logic        mem_req, mem_ack;
   logic        pc_en, fd_en, em_en, fd_flush, de_flush;
   logic [1:0]  state;
   logic [31:0] stall_cycles, flush_cycles;

   int n_vec;
   int n_bad;
   logic [6:0] exp_q[$];

   // {pc_en, fd_en, em_en, fd_flush, de_flush, state}
   localparam logic [6:0] E_RST    = 7'b000_11_00;
   localparam logic [6:0] E_RUN    = 7'b111_00_00;
   localparam logic [6:0] E_STALL  = 7'b001_01_00;
   localparam logic [6:0] E_FDF    = 7'b111_10_00;
   localparam logic [6:0] E_FLUSH  = 7'b111_10_01;
   localparam logic [6:0] E_WRUN   = 7'b000_00_00;
   localparam logic [6:0] E_WFL    = 7'b000_00_01;
   localparam logic [6:0] E_WAIT   = 7'b000_00_10;
   localparam logic [6:0] E_ACK    = 7'b111_00_10;

   typedef struct {
      string      name;
      logic [1:0] jon;
      logic       ld;
      logic [4:0] rd, rs, rt;
      logic       urs, urt;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[8];

   hazard_ctrl dut (
      .clk          (clk),
      .rstd         (rstd),
      .jon_d        (jon_d),
      .ex_load      (ex_load),
      .ex_rd        (ex_rd),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .mem_req      (mem_req),
      .mem_ack      (mem_ack),
      .pc_en        (pc_en),
      .fd_en        (fd_en),
      .em_en        (em_en),
      .fd_flush     (fd_flush),
      .de_flush     (de_flush),
      .state        (state),
      .stall_cycles (stall_cycles),
      .flush_cycles (flush_cycles)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic drive(input logic [1:0] j, input logic ld, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic mr, input logic ma);
      jon_d = j; ex_load = ld; ex_rd = rd; id_rs = rs; id_rt = rt;
      id_use_rs = urs; id_use_rt = urt; mem_req = mr; mem_ack = ma;
   endtask

   task automatic idle();
      drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // scoreboard: expectation queued at drive time, compared mid-cycle
   task automatic step(input string name, input logic [6:0] e);
      logic [6:0] got;
      logic [6:0] want;
      exp_q.push_back(e);
      @(negedge clk);
      got  = {pc_en, fd_en, em_en, fd_flush, de_flush, state};
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got pc/fd/em=%b%b%b ff/df=%b%b st=%0d, required %b%b%b %b%b st=%0d",
                  name, got[6], got[5], got[4], got[3], got[2], got[1:0],
                  want[6], want[5], want[4], want[3], want[2], want[1:0]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, want);
      end
   endtask

   task automatic do_reset();
      rstd = 1'b0;
      idle();
      step("reset_outputs", E_RST);
      rstd = 1'b1;
   endtask

   task automatic chk_counters(input string name, input int st, input int fl);
`ifdef HAZ_PERF_CNT_EN
      chk32({name, "_stall"}, stall_cycles, 32'(st));
      chk32({name, "_flush"}, flush_cycles, 32'(fl));
`else
      chk32({name, "_stall"}, stall_cycles, 32'd0);
      chk32({name, "_flush"}, flush_cycles, 32'd0);
`endif
   endtask

   initial begin
      logic [4:0] rd, rs, rt;
      logic       ld, urs, urt, hz;

      n_vec = 0;
      n_bad = 0;
      rstd  = 1'b0;
      idle();
      #1;

      vecs[0] = '{"idle",          2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_RUN};
      vecs[1] = '{"jon01",         2'b01, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_FDF};
      vecs[2] = '{"ldu_rs",        2'b00, 1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, E_STALL};
      vecs[3] = '{"ldu_rt",        2'b00, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1, E_STALL};
      vecs[4] = '{"ldu_r0",        2'b00, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, E_RUN};
      vecs[5] = '{"ldu_unused",    2'b00, 1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, E_RUN};
      vecs[6] = '{"ldu_noload",    2'b00, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, E_RUN};
      vecs[7] = '{"jon01_over_ld", 2'b01, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, E_FDF};

      do_reset();
      chk_counters("reset", 0, 0);

      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].jon, vecs[i].ld, vecs[i].rd, vecs[i].rs, vecs[i].rt,
               vecs[i].urs, vecs[i].urt, 1'b0, 1'b0);
         step(vecs[i].name, vecs[i].exp);
      end

      // random load-use patterns in RUN, small register range to force matches
      for (int i = 0; i < 24; i++) begin
         ld  = 1'($urandom_range(0, 1));
         urs = 1'($urandom_range(0, 1));
         urt = 1'($urandom_range(0, 1));
         rd  = 5'($urandom_range(0, 3));
         rs  = 5'($urandom_range(0, 3));
         rt  = 5'($urandom_range(0, 3));
         hz  = ld && (rd != 5'd0) && ((urs && rs == rd) || (urt && rt == rd));
         drive(2'b00, ld, rd, rs, rt, urs, urt, 1'b0, 1'b0);
         step("rand_ldu", hz ? E_STALL : E_RUN);
      end

      // taken jump: three flush cycles, states 0,1,1,0
      drive(2'b10, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("jmp_c0", E_FDF);
      idle();
      step("jmp_c1", E_FLUSH);
      step("jmp_c2", E_FLUSH);
      step("jmp_back_run", E_RUN);

      // jump beats load-use; hazard ignored during FLUSH, honoured afterwards
      drive(2'b10, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step("jmp_ld_c0", E_FDF);
      drive(2'b00, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step("jmp_ld_c1", E_FLUSH);
      step("jmp_ld_c2", E_FLUSH);
      step("jmp_ld_stall", E_STALL);

      // jump reload while in FLUSH extends the sequence
      drive(2'b10, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("reload_c0", E_FDF);
      step("reload_c1", E_FLUSH);
      idle();
      step("reload_c2", E_FLUSH);
      step("reload_c3", E_FLUSH);
      step("reload_run", E_RUN);

      // memory wait of 4 cycles from RUN, then ack
      do_reset();
      drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("mw_c0", E_WRUN);
      step("mw_c1", E_WAIT);
      step("mw_c2", E_WAIT);
      step("mw_c3", E_WAIT);
      mem_ack = 1'b1;
      step("mw_ack", E_ACK);
      idle();
      step("mw_after", E_RUN);
      chk_counters("mw", 4, 0);

      // memory wait inside FLUSH: fcnt frozen, resume FLUSH after ack
      do_reset();
      drive(2'b10, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("fw_jmp", E_FDF);
      drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("fw_wait0", E_WFL);
      drive(2'b10, 1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      step("fw_wait1_ignore", E_WAIT);
      drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      step("fw_ack", E_ACK);
      idle();
      step("fw_flush1", E_FLUSH);
      step("fw_flush2", E_FLUSH);
      step("fw_run", E_RUN);
      chk_counters("fw", 2, 3);

      // reset asserted in the middle of MEMWAIT
      drive(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("rmw_c0", E_WRUN);
      step("rmw_c1", E_WAIT);
      rstd = 1'b0;
      step("rmw_in_reset", E_RST);
      rstd = 1'b1;
      idle();
      step("rmw_after", E_RUN);
      chk_counters("rmw", 0, 0);

      // reset mid-FLUSH: first cycle after release is plain RUN
      drive(2'b10, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("rfl_jmp", E_FDF);
      do_reset();
      step("rfl_after", E_RUN);

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
